// File: rtl/register_file.sv
// 32-entry register file: one-hot write select, two combinational read ports, bulk-clear engine.
// Optional same-cycle write-through on the read ports is enabled by defining REG_FILE_BYPASS_EN.
module register_file #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_REGS    = 32,
  parameter int BITS        = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Reg_Write_i,
  input  logic [NUM_REGS-1:0]    Write_Sel_i,
  input  logic [WORD_LENGTH-1:0] Write_Data_i,
  input  logic [BITS-1:0]        Read_Register_1_i,
  input  logic [BITS-1:0]        Read_Register_2_i,
  input  logic                   Clear_i,
  output logic [WORD_LENGTH-1:0] Read_Data_1_o,
  output logic [WORD_LENGTH-1:0] Read_Data_2_o,
  output logic                   Busy_o,
  output logic                   Sel_Error_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [BITS-1:0] LAST_REG = BITS'(NUM_REGS - 1);
  localparam logic [BITS-1:0] FIRST_REG = {{(BITS-1){1'b0}}, 1'b1};

  // More than one bit set: v & (v - 1) clears the lowest set bit.
  function automatic logic is_multi_hot(input logic [NUM_REGS-1:0] v);
    return |(v & (v - {{(NUM_REGS-1){1'b0}}, 1'b1}));
  endfunction

  logic [WORD_LENGTH-1:0] regs_r [NUM_REGS-1:1];
  state_t                 state_r;
  logic [BITS-1:0]        cnt_r;
  logic                   busy_r;
  logic                   sel_error_r;

  logic [NUM_REGS-1:0]    sel_masked_s;
  logic                   multi_hot_s;
  logic                   write_ok_s;
  logic [BITS-1:0]        wr_idx_s;
  logic [WORD_LENGTH-1:0] stored_1_s;
  logic [WORD_LENGTH-1:0] stored_2_s;

  // Write-select qualification; bit 0 never participates.
  always_comb begin
    sel_masked_s    = Write_Sel_i;
    sel_masked_s[0] = 1'b0;
    multi_hot_s     = is_multi_hot(sel_masked_s);
    write_ok_s      = Reg_Write_i && (state_r == IDLE) && !multi_hot_s && (|sel_masked_s);
    wr_idx_s        = {BITS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      wr_idx_s = wr_idx_s | (sel_masked_s[i] ? BITS'(i) : {BITS{1'b0}});
    end
  end

  // Storage, clear-engine FSM and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_r[i] <= {WORD_LENGTH{1'b0}};
      end
      state_r     <= IDLE;
      cnt_r       <= FIRST_REG;
      busy_r      <= 1'b0;
      sel_error_r <= 1'b0;
    end else begin
      sel_error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (write_ok_s) begin
            regs_r[wr_idx_s] <= Write_Data_i;
          end
          if (Reg_Write_i && multi_hot_s) begin
            sel_error_r <= 1'b1;
          end
          if (Clear_i) begin
            state_r <= CLEAR;
            cnt_r   <= FIRST_REG;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        CLEAR: begin
          regs_r[cnt_r] <= {WORD_LENGTH{1'b0}};
          if (cnt_r == LAST_REG) begin
            state_r <= IDLE;
            cnt_r   <= FIRST_REG;
            busy_r  <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + FIRST_REG;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= FIRST_REG;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational read ports; register 0 is hard-wired to zero.
  always_comb begin
    if (Read_Register_1_i != {BITS{1'b0}}) begin
      stored_1_s = regs_r[Read_Register_1_i];
    end else begin
      stored_1_s = {WORD_LENGTH{1'b0}};
    end
    if (Read_Register_2_i != {BITS{1'b0}}) begin
      stored_2_s = regs_r[Read_Register_2_i];
    end else begin
      stored_2_s = {WORD_LENGTH{1'b0}};
    end
`ifdef REG_FILE_BYPASS_EN
    // write_ok_s implies IDLE and a nonzero target, so no bypass while busy or for register 0.
    Read_Data_1_o = (write_ok_s && (Read_Register_1_i == wr_idx_s)) ? Write_Data_i : stored_1_s;
    Read_Data_2_o = (write_ok_s && (Read_Register_2_i == wr_idx_s)) ? Write_Data_i : stored_2_s;
`else
    Read_Data_1_o = stored_1_s;
    Read_Data_2_o = stored_2_s;
`endif
  end

  assign Busy_o      = busy_r;
  assign Sel_Error_o = sel_error_r;

endmodule
